// File: rtl/rs_multi_issue.sv
// Multi-issue reservation station with CDB wakeup, branch-mask squash/clear, and
// lowest-index-first selection across ISSUE_WIDTH independent lanes.
module rs_multi_issue #(
  parameter int unsigned RS_SIZE     = 8,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned TAG_W       = 6,
  parameter int unsigned BMASK_W     = 4,
  parameter int unsigned PAYLOAD_W   = 32
) (
  input  logic                             clock_i,
  input  logic                             reset_ni,
  input  logic                             disp_valid_i,
  input  logic [TAG_W-1:0]                 disp_t_i,
  input  logic [TAG_W-1:0]                 disp_t1_i,
  input  logic                             disp_t1r_i,
  input  logic [TAG_W-1:0]                 disp_t2_i,
  input  logic                             disp_t2r_i,
  input  logic [BMASK_W-1:0]               disp_bmask_i,
  input  logic [PAYLOAD_W-1:0]             disp_payload_i,
  input  logic                             cdb_valid_i,
  input  logic [TAG_W-1:0]                 cdb_tag_i,
  input  logic                             br_valid_i,
  input  logic [BMASK_W-1:0]               br_mask_i,
  input  logic                             br_mispredict_i,
  input  logic [ISSUE_WIDTH-1:0]           iss_ready_i,
  output logic [ISSUE_WIDTH-1:0]           iss_valid_o,
  output logic [ISSUE_WIDTH*TAG_W-1:0]     iss_t_o,
  output logic [ISSUE_WIDTH*BMASK_W-1:0]   iss_bmask_o,
  output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] iss_payload_o,
  output logic                             rs_full_o,
  output logic                             rs_available_o,
  output logic [$clog2(RS_SIZE+1)-1:0]     free_count_o
);

  localparam int unsigned IdxW = $clog2(RS_SIZE);
  localparam int unsigned CntW = $clog2(RS_SIZE+1);

  logic [RS_SIZE-1:0]   valid_q, valid_d;
  logic [RS_SIZE-1:0]   t1r_q, t1r_d;
  logic [RS_SIZE-1:0]   t2r_q, t2r_d;
  logic [TAG_W-1:0]     t_q [RS_SIZE];
  logic [TAG_W-1:0]     t_d [RS_SIZE];
  logic [TAG_W-1:0]     t1_q [RS_SIZE];
  logic [TAG_W-1:0]     t1_d [RS_SIZE];
  logic [TAG_W-1:0]     t2_q [RS_SIZE];
  logic [TAG_W-1:0]     t2_d [RS_SIZE];
  logic [BMASK_W-1:0]   bmask_q [RS_SIZE];
  logic [BMASK_W-1:0]   bmask_d [RS_SIZE];
  logic [PAYLOAD_W-1:0] payload_q [RS_SIZE];
  logic [PAYLOAD_W-1:0] payload_d [RS_SIZE];

  logic [CntW-1:0] free_q, free_d;
  logic            full_q, full_d;
  logic            avail_q, avail_d;

  logic [RS_SIZE-1:0]     rdy;
  logic [RS_SIZE-1:0]     sq;
  logic [RS_SIZE-1:0]     issued;
  logic [IdxW-1:0]        sel_idx [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] sel_vld;
  logic [IdxW-1:0]        free_idx;
  logic                   free_found;
  logic                   br_clr, br_sq;
  logic [BMASK_W-1:0]     keep_mask;
  logic                   disp_we;

  assign br_clr    = br_valid_i & ~br_mispredict_i;
  assign br_sq     = br_valid_i & br_mispredict_i;
  assign keep_mask = br_clr ? ~br_mask_i : {BMASK_W{1'b1}};

  always_comb begin
    rdy = '0;
    sq  = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      rdy[i] = valid_q[i] & t1r_q[i] & t2r_q[i];
      sq[i]  = br_sq & (|(bmask_q[i] & br_mask_i));
    end
  end

  // Lane k picks the k-th lowest-index ready entry.
  always_comb begin
    int unsigned n;
    sel_vld = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      sel_idx[k] = '0;
      n = 0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (rdy[i]) begin
          if (n == k && !sel_vld[k]) begin
            sel_idx[k] = IdxW'(i);
            sel_vld[k] = 1'b1;
          end
          n++;
        end
      end
    end
  end

  always_comb begin
    iss_valid_o   = '0;
    iss_t_o       = '0;
    iss_bmask_o   = '0;
    iss_payload_o = '0;
    issued        = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      iss_valid_o[k] = sel_vld[k] & ~sq[sel_idx[k]];
      iss_t_o[k*TAG_W +: TAG_W]             = t_q[sel_idx[k]];
      iss_bmask_o[k*BMASK_W +: BMASK_W]     = bmask_q[sel_idx[k]] & keep_mask;
      iss_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[sel_idx[k]];
      if (iss_valid_o[k] && iss_ready_i[k]) begin
        issued[sel_idx[k]] = 1'b1;
      end
    end
  end

  // Free slot is chosen from the current state, so same-cycle issue frees are not reused.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IdxW'(i);
        free_found = 1'b1;
      end
    end
  end

  assign disp_we = disp_valid_i & ~full_q & free_found &
                   ~(br_sq & (|(disp_bmask_i & br_mask_i)));

  always_comb begin
    valid_d   = valid_q;
    t1r_d     = t1r_q;
    t2r_d     = t2r_q;
    t_d       = t_q;
    t1_d      = t1_q;
    t2_d      = t2_q;
    bmask_d   = bmask_q;
    payload_d = payload_q;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (cdb_valid_i && valid_q[i] && t1_q[i] == cdb_tag_i) t1r_d[i] = 1'b1;
      if (cdb_valid_i && valid_q[i] && t2_q[i] == cdb_tag_i) t2r_d[i] = 1'b1;
      bmask_d[i] = bmask_q[i] & keep_mask;
      if (issued[i] || (valid_q[i] && sq[i])) valid_d[i] = 1'b0;
    end
    if (disp_we) begin
      valid_d[free_idx]   = 1'b1;
      t_d[free_idx]       = disp_t_i;
      t1_d[free_idx]      = disp_t1_i;
      t2_d[free_idx]      = disp_t2_i;
      t1r_d[free_idx]     = disp_t1r_i | (cdb_valid_i && disp_t1_i == cdb_tag_i);
      t2r_d[free_idx]     = disp_t2r_i | (cdb_valid_i && disp_t2_i == cdb_tag_i);
      bmask_d[free_idx]   = disp_bmask_i & keep_mask;
      payload_d[free_idx] = disp_payload_i;
    end
  end

  // Count of invalid entries after the edge; bounded by construction.
  always_comb begin
    free_d = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!valid_d[i]) free_d = free_d + CntW'(1);
    end
    full_d  = (free_d == '0);
    avail_d = ~full_d;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      valid_q <= '0;
      free_q  <= CntW'(RS_SIZE);
      full_q  <= 1'b0;
      avail_q <= 1'b1;
    end else begin
      valid_q <= valid_d;
      free_q  <= free_d;
      full_q  <= full_d;
      avail_q <= avail_d;
    end
  end

  always_ff @(posedge clock_i) begin
    t1r_q     <= t1r_d;
    t2r_q     <= t2r_d;
    t_q       <= t_d;
    t1_q      <= t1_d;
    t2_q      <= t2_d;
    bmask_q   <= bmask_d;
    payload_q <= payload_d;
  end

  assign rs_full_o      = full_q;
  assign rs_available_o = avail_q;
  assign free_count_o   = free_q;

endmodule
